mem_port_arbiter: RTL and testbench

Shares the single 128-bit block port of main memory between two cache controllers, for example an instruction cache and a data cache of the 2-way write-through type.
- Each requester issues whole-block reads (line fills) or whole-block writes (write-through updates) with a req/ack handshake.
- The arbiter grants requests round-robin, sequences the fixed-latency memory access, and returns read data to the winner.
- It sits between the caches and the main memory model and is the only master of the memory port.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency block memory port between two requesters.
// Sequences IDLE -> ACCESS (MEM_LAT cycles) -> DONE and returns read data to the winner.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned MEM_LAT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam int unsigned   CntW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MEM_LAT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [ADDR_W-1:0] BlkMask = ~ADDR_W'(15);

  logic [1:0]        r_state;
  logic              r_last;
  logic              r_win;
  logic [CntW-1:0]   r_cnt;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;

  logic              w_any_req;
  logic              w_win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // On a tie the port that was not served last wins; a lone requester always wins.
  always_comb begin
    w_any_req = i_req0 | i_req1;
    w_win     = (i_req0 & i_req1) ? ~r_last : i_req1;
    w_we      = w_win ? i_we1 : i_we0;
    w_addr    = w_win ? i_addr1 : i_addr0;
    w_wdata   = w_win ? i_wdata1 : i_wdata0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_last      <= 1'b1;
      r_win       <= 1'b0;
      r_cnt       <= '0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_win       <= w_win;
            r_mem_we    <= w_we;
            r_mem_addr  <= w_addr & BlkMask;
            r_mem_wdata <= w_wdata;
            r_cnt       <= CntInit;
            r_mem_en    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= StAccess;
          end
        end
        StAccess: begin
          if (r_cnt == '0) begin
            // mem_we still holds the latched direction during the final access cycle.
            if (!r_mem_we) begin
              if (r_win) r_rdata1 <= i_mem_rdata;
              else       r_rdata0 <= i_mem_rdata;
            end
            r_ack0   <= ~r_win;
            r_ack1   <= r_win;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= StDone;
          end else begin
            r_cnt <= r_cnt - CntOne;
          end
        end
        StDone: begin
          r_last  <= r_win;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_ack0      = r_ack0;
  assign o_ack1      = r_ack1;
  assign o_rdata0    = r_rdata0;
  assign o_rdata1    = r_rdata1;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=4 on a block memory model,
// one with MEM_LAT=1 fed a fixed read value.
module tb_mem_port_arbiter;

  localparam logic [127:0] PatA = {16{8'hA5}};
  localparam logic [127:0] PatB = {8{16'hB00B}};
  localparam logic [127:0] PatC = {4{32'hC0DE_F00D}};
  localparam logic [127:0] PatW = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         req0, req1, we0, we1;
  logic [9:0]   addr0, addr1;
  logic [127:0] wdata0, wdata1;
  logic         ack0, ack1, mem_en, mem_we, busy;
  logic [127:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [9:0]   mem_addr;

  logic         l_req0, l_req1, l_we0, l_we1;
  logic [9:0]   l_addr0, l_addr1;
  logic [127:0] l_wdata0, l_wdata1;
  logic         l_ack0, l_ack1, l_mem_en, l_mem_we, l_busy;
  logic [127:0] l_rdata0, l_rdata1, l_mem_wdata, l_mem_rdata;
  logic [9:0]   l_mem_addr;

  int checks = 0;
  int errors = 0;

  logic [127:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[9:4]];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[9:4]] <= mem_wdata;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(128), .MEM_LAT(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(128), .MEM_LAT(1)) u_dut_lat1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(l_req0), .i_req1(l_req1), .i_we0(l_we0), .i_we1(l_we1),
    .i_addr0(l_addr0), .i_addr1(l_addr1), .i_wdata0(l_wdata0), .i_wdata1(l_wdata1),
    .o_ack0(l_ack0), .o_ack1(l_ack1), .o_rdata0(l_rdata0), .o_rdata1(l_rdata1),
    .o_mem_en(l_mem_en), .o_mem_we(l_mem_we), .o_mem_addr(l_mem_addr),
    .o_mem_wdata(l_mem_wdata), .i_mem_rdata(l_mem_rdata), .o_busy(l_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst_n high in the current cycle, so a request set now is sampled at the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({ack0, ack1, mem_en, mem_we, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {ack0, ack1, mem_en, mem_we, busy});
    end
    checks++;
    if (rdata0 !== '0 || rdata1 !== '0) begin
      errors++;
      $display("FAIL reset_rdata got %h/%h want 0/0", rdata0, rdata1);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem got %h/%h want 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if ({l_ack0, l_ack1, l_mem_en, l_busy} !== 4'b0000 || l_rdata1 !== '0) begin
      errors++;
      $display("FAIL reset_lat1 got %b rdata1 %h want 0000 and 0",
               {l_ack0, l_ack1, l_mem_en, l_busy}, l_rdata1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    int en_cnt;
    int ack_cnt;
    int ack_at;
    bit saw_ack1;
    en_cnt = 0; ack_cnt = 0; ack_at = 0; saw_ack1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h2A4;
    for (int c = 2; c <= 7; c++) begin
      step();
      if (mem_en) begin
        en_cnt++;
        checks++;
        if (mem_addr !== 10'h2A0 || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL read_mem_addr cycle %0d got %h we %b want 2a0 we 0", c, mem_addr, mem_we);
        end
      end
      if (ack0) begin
        ack_cnt++;
        if (ack_at == 0) ack_at = c;
        req0 = 1'b0;
      end
      if (ack1) saw_ack1 = 1'b1;
    end
    checks++;
    if (en_cnt != 4) begin
      errors++;
      $display("FAIL read_en_cycles got %0d want 4", en_cnt);
    end
    checks++;
    if (ack_at != 6 || ack_cnt != 1) begin
      errors++;
      $display("FAIL read_ack0 got cycle %0d count %0d want cycle 6 count 1", ack_at, ack_cnt);
    end
    checks++;
    if (rdata0 !== PatA) begin
      errors++;
      $display("FAIL read_rdata0 got %h want %h", rdata0, PatA);
    end
    checks++;
    if (saw_ack1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL read_idle got ack1_seen %b busy %b want 0 0", saw_ack1, busy);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    int port [4];
    int cyc [4];
    int n0;
    n = 0; n0 = 0;
    for (int i = 0; i < 4; i++) begin port[i] = -1; cyc[i] = 0; end
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h2A4;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h300;
    for (int c = 2; c <= 26; c++) begin
      step();
      if (ack0 && n < 4) begin port[n] = 0; cyc[n] = c; n++; end
      if (ack1 && n < 4) begin port[n] = 1; cyc[n] = c; n++; end
      if (ack0) begin n0++; req0 = 1'b0; end
      // First ack1: re-assert both ports together; second ack1: stop.
      if (ack1) begin
        if (n0 == 1) req0 = 1'b1;
        else req1 = 1'b0;
      end
    end
    checks++;
    if (port[0] != 0 || cyc[0] != 6) begin
      errors++;
      $display("FAIL tie_first got port %0d cycle %0d want port 0 cycle 6", port[0], cyc[0]);
    end
    checks++;
    if (port[1] != 1 || cyc[1] != 12) begin
      errors++;
      $display("FAIL tie_second got port %0d cycle %0d want port 1 cycle 12", port[1], cyc[1]);
    end
    checks++;
    if (port[2] != 0 || cyc[2] != 18 || port[3] != 1 || cyc[3] != 24) begin
      errors++;
      $display("FAIL tie_again got %0d@%0d %0d@%0d want 0@18 1@24",
               port[2], cyc[2], port[3], cyc[3]);
    end
    checks++;
    if (rdata0 !== PatA || rdata1 !== PatB) begin
      errors++;
      $display("FAIL tie_rdata got %h/%h want %h/%h", rdata0, rdata1, PatA, PatB);
    end
    step();
  endtask

  task automatic test_fairness();
    int n;
    int port [3];
    int cyc [3];
    int n0;
    n = 0; n0 = 0;
    for (int i = 0; i < 3; i++) begin port[i] = -1; cyc[i] = 0; end
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h2A4;
    req1 = 1'b0; we1 = 1'b0; addr1 = 10'h300;
    for (int c = 2; c <= 19; c++) begin
      step();
      if (c == 3) req1 = 1'b1;
      if (ack0 && n < 3) begin port[n] = 0; cyc[n] = c; n++; end
      if (ack1 && n < 3) begin port[n] = 1; cyc[n] = c; n++; end
      if (ack0) begin n0++; if (n0 == 2) req0 = 1'b0; end
      if (ack1) req1 = 1'b0;
    end
    checks++;
    if (port[0] != 0 || cyc[0] != 6) begin
      errors++;
      $display("FAIL fair_first got port %0d cycle %0d want port 0 cycle 6", port[0], cyc[0]);
    end
    checks++;
    if (port[1] != 1 || cyc[1] != 12) begin
      errors++;
      $display("FAIL fair_second got port %0d cycle %0d want port 1 cycle 12", port[1], cyc[1]);
    end
    checks++;
    if (port[2] != 0 || cyc[2] != 18 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fair_third got port %0d cycle %0d busy %b want port 0 cycle 18 busy 0",
               port[2], cyc[2], busy);
    end
  endtask

  task automatic test_write_read();
    int we_cnt;
    int ack_at;
    bit bad_bus;
    we_cnt = 0; ack_at = 0; bad_bus = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h150; wdata1 = PatW;
    for (int c = 2; c <= 7; c++) begin
      step();
      if (mem_we) begin
        we_cnt++;
        if (!mem_en || mem_addr !== 10'h150 || mem_wdata !== PatW) bad_bus = 1'b1;
      end
      if (ack1) begin
        if (ack_at == 0) ack_at = c;
        req1 = 1'b0; we1 = 1'b0;
      end
    end
    checks++;
    if (we_cnt != 4 || bad_bus) begin
      errors++;
      $display("FAIL write_bus got we_cycles %0d bad %b want 4 0", we_cnt, bad_bus);
    end
    checks++;
    if (ack_at != 6 || rdata1 !== PatB) begin
      errors++;
      $display("FAIL write_ack1 got cycle %0d rdata1 %h want 6 %h", ack_at, rdata1, PatB);
    end
    checks++;
    if (mem[6'h15] !== PatW) begin
      errors++;
      $display("FAIL write_commit got %h want %h", mem[6'h15], PatW);
    end
    ack_at = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h15C;
    for (int c = 2; c <= 7; c++) begin
      step();
      if (ack0) begin
        if (ack_at == 0) ack_at = c;
        req0 = 1'b0;
      end
    end
    checks++;
    if (ack_at != 6 || rdata0 !== PatW || rdata1 !== PatB) begin
      errors++;
      $display("FAIL readback got cycle %0d rdata0 %h rdata1 %h want 6 %h %h",
               ack_at, rdata0, rdata1, PatW, PatB);
    end
  endtask

  task automatic test_reset_mid_access();
    int ack_at;
    bit early_ack;
    ack_at = 0; early_ack = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h2A4;
    step();
    step();
    if (ack0) early_ack = 1'b1;
    rst_n = 1'b0;
    step();
    checks++;
    if ({mem_en, busy, ack0} !== 3'b000 || rdata0 !== '0 || early_ack) begin
      errors++;
      $display("FAIL midrst_state got en/busy/ack %b rdata0 %h early %b want 000 0 0",
               {mem_en, busy, ack0}, rdata0, early_ack);
    end
    rst_n = 1'b1;
    for (int c = 2; c <= 7; c++) begin
      step();
      if (ack0) begin
        if (ack_at == 0) ack_at = c;
        req0 = 1'b0;
      end
    end
    checks++;
    if (ack_at != 6 || rdata0 !== PatA) begin
      errors++;
      $display("FAIL midrst_retry got cycle %0d rdata0 %h want 6 %h", ack_at, rdata0, PatA);
    end
  endtask

  task automatic test_lat1();
    int en_cnt;
    int ack_at;
    en_cnt = 0; ack_at = 0;
    l_req1 = 1'b1; l_we1 = 1'b0; l_addr1 = 10'h0F8;
    for (int c = 2; c <= 5; c++) begin
      step();
      if (l_mem_en) begin
        en_cnt++;
        checks++;
        if (l_mem_addr !== 10'h0F0) begin
          errors++;
          $display("FAIL lat1_addr got %h want 0f0", l_mem_addr);
        end
      end
      if (l_ack1) begin
        if (ack_at == 0) ack_at = c;
        l_req1 = 1'b0;
      end
    end
    checks++;
    if (en_cnt != 1 || ack_at != 3) begin
      errors++;
      $display("FAIL lat1_timing got en_cycles %0d ack cycle %0d want 1 3", en_cnt, ack_at);
    end
    checks++;
    if (l_rdata1 !== PatC || l_rdata0 !== '0 || l_busy !== 1'b0) begin
      errors++;
      $display("FAIL lat1_rdata got %h/%h busy %b want %h/0 0", l_rdata1, l_rdata0, l_busy, PatC);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[6'h2A] = PatA;
    mem[6'h30] = PatB;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    l_req0 = 1'b0; l_req1 = 1'b0; l_we0 = 1'b0; l_we1 = 1'b0;
    l_addr0 = '0; l_addr1 = '0; l_wdata0 = '0; l_wdata1 = '0;
    l_mem_rdata = PatC;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_write_read();
    test_reset_mid_access();
    test_lat1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
